list_sum_engine: RTL and testbench

LIST_SUM_ENGINE -- requirements
Module: list_sum_engine

---
 rtl/list_sum_engine.sv | 254 +++++++++++++++++++++++++
 tb/tb_list_sum_engine.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/list_sum_engine.sv
// list_sum_engine
//
// Walks a proper lisp list of NUMBER cells held in an external cell memory,
// sums the number cars (modulo 2^16), counts the elements, then allocates a
// fresh NUMBER cell holding the sum and reports its header address.
//
// Cell memory protocol: the engine raises mem_read_enable or mem_write_enable
// for exactly one cycle together with a stable address/payload, then waits for
// a one-cycle mem_done. Address and payload are held until mem_done (or until
// the wait times out). At most one request is ever outstanding, and mem_done
// is only honoured while a request is outstanding.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start, list_ptr    one-cycle start pulse and list header address (Idle only)
//   busy, done         walk in progress / one-cycle completion pulse
//   err_code           0 ok, 1 bad type, 2 overlength, 3 memory timeout
//   sum, count         running sum of number cars and number of elements summed
//   result_ptr         header address of the written result cell (err_code 0)
//   mem_read_enable    read request pulse, mem_addr is the cell header address
//   mem_header/car/cdr read response, valid with mem_done
//   mem_write_enable   allocate/write request pulse with mem_data_type,
//                      mem_car_data and mem_cdr_data as payload
//   mem_ptr            allocated header address, valid with mem_done of a write
//   mem_done           memory completion pulse
//   dbg_state          current FSM state, for observation only
//
// MemTimeout must be at least 2: the request cycle counts as the first cycle
// of the timeout window.

module list_sum_engine #(
  parameter int MaxLen     = 255,
  parameter int MemTimeout = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] list_ptr,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [15:0] sum,
  output logic [7:0]  count,
  output logic [15:0] result_ptr,
  output logic        mem_read_enable,
  output logic [15:0] mem_addr,
  input  logic [14:0] mem_header,
  input  logic [15:0] mem_car,
  input  logic [15:0] mem_cdr,
  output logic        mem_write_enable,
  output logic [14:0] mem_data_type,
  output logic [15:0] mem_car_data,
  output logic [15:0] mem_cdr_data,
  input  logic [15:0] mem_ptr,
  input  logic        mem_done,
  output logic [2:0]  dbg_state
);

  // Lisp cell encoding shared with the rest of the machine.
  localparam logic [15:0] LISP_NIL    = 16'h0000;
  localparam logic [14:0] TYPE_CONS   = 15'd1;
  localparam logic [14:0] TYPE_NUMBER = 15'd2;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_TYPE     = 2'd1;
  localparam logic [1:0] ERR_OVERLEN  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0] MAX_LEN_C = 8'(MaxLen);

  // The timer starts at 1 in the Req cycle, so the wait state gives up after
  // MemTimeout-1 cycles and done appears MemTimeout cycles after the request.
  localparam int            TW      = $clog2(MemTimeout + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(MemTimeout - 1);
  localparam logic [TW-1:0] TW_ONE  = TW'(1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REQ_CELL   = 3'd1,
    WAIT_CELL  = 3'd2,
    REQ_CAR    = 3'd3,
    WAIT_CAR   = 3'd4,
    REQ_WRITE  = 3'd5,
    WAIT_WRITE = 3'd6,
    FINISH     = 3'd7
  } state_t;

  state_t        state;
  logic [15:0]   next_ptr;   // cdr of the cell currently being summed
  logic [TW-1:0] timer;

  logic [15:0]   sum_upd;
  logic [7:0]    count_upd;
  logic          timed_out;

  assign sum_upd   = sum + mem_car;
  assign count_upd = count + 8'd1;
  assign timed_out = (timer == TO_LAST);
  assign dbg_state = state;

  // mem_addr doubles as the walk cursor: it is loaded with the cell or car
  // address on the transition into the Req state and held through the wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      next_ptr         <= 16'd0;
      timer            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_code         <= ERR_OK;
      sum              <= 16'd0;
      count            <= 8'd0;
      result_ptr       <= 16'd0;
      mem_read_enable  <= 1'b0;
      mem_addr         <= 16'd0;
      mem_write_enable <= 1'b0;
      mem_data_type    <= 15'd0;
      mem_car_data     <= 16'd0;
      mem_cdr_data     <= 16'd0;
    end else begin
      // Pulses default low; each is raised only on entry to its state.
      done             <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            sum        <= 16'd0;
            count      <= 8'd0;
            err_code   <= ERR_OK;
            result_ptr <= 16'd0;
            if (list_ptr == LISP_NIL) begin
              // Empty list: nothing to read, write a zero-valued result.
              state            <= REQ_WRITE;
              mem_write_enable <= 1'b1;
              mem_data_type    <= TYPE_NUMBER;
              mem_car_data     <= 16'd0;
              mem_cdr_data     <= LISP_NIL;
            end else begin
              state           <= REQ_CELL;
              mem_read_enable <= 1'b1;
              mem_addr        <= list_ptr;
            end
          end
        end

        REQ_CELL: begin
          state <= WAIT_CELL;
          timer <= TW_ONE;
        end

        WAIT_CELL: begin
          if (mem_done) begin
            if (mem_header != TYPE_CONS) begin
              err_code <= ERR_TYPE;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= FINISH;
            end else begin
              next_ptr        <= mem_cdr;
              mem_addr        <= mem_car;
              mem_read_enable <= 1'b1;
              state           <= REQ_CAR;
            end
          end else if (timed_out) begin
            err_code <= ERR_TIMEOUT;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= FINISH;
          end else begin
            timer <= timer + TW_ONE;
          end
        end

        REQ_CAR: begin
          state <= WAIT_CAR;
          timer <= TW_ONE;
        end

        WAIT_CAR: begin
          if (mem_done) begin
            if (mem_header != TYPE_NUMBER) begin
              err_code <= ERR_TYPE;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= FINISH;
            end else begin
              sum   <= sum_upd;
              count <= count_upd;
              // End of list wins over the length limit: a list of exactly
              // MaxLen elements is accepted.
              if (next_ptr == LISP_NIL) begin
                state            <= REQ_WRITE;
                mem_write_enable <= 1'b1;
                mem_data_type    <= TYPE_NUMBER;
                mem_car_data     <= sum_upd;
                mem_cdr_data     <= LISP_NIL;
              end else if (count_upd == MAX_LEN_C) begin
                err_code <= ERR_OVERLEN;
                done     <= 1'b1;
                busy     <= 1'b0;
                state    <= FINISH;
              end else begin
                mem_addr        <= next_ptr;
                mem_read_enable <= 1'b1;
                state           <= REQ_CELL;
              end
            end
          end else if (timed_out) begin
            err_code <= ERR_TIMEOUT;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= FINISH;
          end else begin
            timer <= timer + TW_ONE;
          end
        end

        REQ_WRITE: begin
          state <= WAIT_WRITE;
          timer <= TW_ONE;
        end

        WAIT_WRITE: begin
          if (mem_done) begin
            result_ptr <= mem_ptr;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= FINISH;
          end else if (timed_out) begin
            err_code <= ERR_TIMEOUT;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= FINISH;
          end else begin
            timer <= timer + TW_ONE;
          end
        end

        FINISH: begin
          // done is high for this single cycle; results stay visible.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_list_sum_engine.sv
// tb_list_sum_engine
//
// Bench for list_sum_engine with a small cell-memory model (fixed two-cycle
// latency, allocator starting at 0x22) and directed list walks. Expected
// read addresses, write payloads and completion results are pushed into
// queues before each walk; a monitor on the falling edge pops and compares.

module tb_list_sum_engine;

  localparam int MAX_LEN     = 4;
  localparam int MEM_TIMEOUT = 16;

  localparam logic [15:0] NIL    = 16'h0000;
  localparam logic [14:0] T_NIL  = 15'd0;
  localparam logic [14:0] T_CONS = 15'd1;
  localparam logic [14:0] T_NUM  = 15'd2;
  localparam logic [14:0] T_PRIM = 15'd3;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] list_ptr;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [15:0] sum;
  logic [7:0]  count;
  logic [15:0] result_ptr;
  logic        mem_read_enable;
  logic [15:0] mem_addr;
  logic [14:0] mem_header;
  logic [15:0] mem_car;
  logic [15:0] mem_cdr;
  logic        mem_write_enable;
  logic [14:0] mem_data_type;
  logic [15:0] mem_car_data;
  logic [15:0] mem_cdr_data;
  logic [15:0] mem_ptr;
  logic        mem_done;
  logic [2:0]  dbg_state;

  list_sum_engine #(
    .MaxLen     (MAX_LEN),
    .MemTimeout (MEM_TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .list_ptr         (list_ptr),
    .busy             (busy),
    .done             (done),
    .err_code         (err_code),
    .sum              (sum),
    .count            (count),
    .result_ptr       (result_ptr),
    .mem_read_enable  (mem_read_enable),
    .mem_addr         (mem_addr),
    .mem_header       (mem_header),
    .mem_car          (mem_car),
    .mem_cdr          (mem_cdr),
    .mem_write_enable (mem_write_enable),
    .mem_data_type    (mem_data_type),
    .mem_car_data     (mem_car_data),
    .mem_cdr_data     (mem_cdr_data),
    .mem_ptr          (mem_ptr),
    .mem_done         (mem_done),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters and scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic [15:0] rd_q[$];    // expected read addresses
  logic [46:0] wr_q[$];    // expected {type, car, cdr}
  logic [41:0] done_q[$];  // expected {err, sum, count, result_ptr}

  int done_cnt    = 0;
  int last_rd_cyc = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [14:0] img_hdr[256];
  logic [15:0] img_car[256];
  logic [15:0] img_cdr[256];
  logic        mem_dead;
  logic [15:0] hp;
  int          pend_cnt;
  logic        pend_wr;
  logic [15:0] pend_addr;
  logic [14:0] pend_type;
  logic [15:0] pend_car;
  logic [15:0] pend_cdr;

  task automatic put(input logic [7:0] a, input logic [14:0] h,
                     input logic [15:0] c, input logic [15:0] d);
    img_hdr[a] = h;
    img_car[a] = c;
    img_cdr[a] = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) put(8'(i), T_NIL, 16'h0, 16'h0);
    put(8'h03, T_NUM,  16'h0005, NIL);
    put(8'h06, T_NUM,  16'h0003, NIL);
    put(8'h09, T_CONS, 16'h0006, NIL);
    put(8'h0C, T_CONS, 16'h0003, 16'h0009);
    put(8'h0F, T_CONS, 16'h0012, NIL);
    put(8'h12, T_PRIM, 16'h0001, NIL);
    put(8'h15, T_CONS, 16'h0018, 16'h0015);   // self-cyclic
    put(8'h18, T_NUM,  16'h0001, NIL);
    put(8'h80, T_NUM,  16'hFFF0, NIL);        // wrap-around pair
    put(8'h83, T_NUM,  16'h0020, NIL);
    put(8'h86, T_CONS, 16'h0083, NIL);
    put(8'h89, T_CONS, 16'h0080, 16'h0086);
    put(8'h90, T_CONS, 16'h0018, 16'h0093);   // exactly MAX_LEN elements
    put(8'h93, T_CONS, 16'h0003, 16'h0096);
    put(8'h96, T_CONS, 16'h0006, 16'h0099);
    put(8'h99, T_CONS, 16'h0018, NIL);
    hp         = 16'h0022;  // heap at 0x20, two bookkeeping words first
    pend_cnt   = 0;
    pend_wr    = 1'b0;
    pend_addr  = 16'h0;
    pend_type  = 15'h0;
    pend_car   = 16'h0;
    pend_cdr   = 16'h0;
    mem_done   = 1'b0;
    mem_header = 15'h0;
    mem_car    = 16'h0;
    mem_cdr    = 16'h0;
    mem_ptr    = 16'h0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (rst) begin
        pend_cnt = 0;
      end else if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_done = 1'b1;
          if (pend_wr) begin
            mem_ptr = hp;
            put(hp[7:0], pend_type, pend_car, pend_cdr);
            hp = hp + 16'd3;
          end else begin
            mem_header = img_hdr[pend_addr[7:0]];
            mem_car    = img_car[pend_addr[7:0]];
            mem_cdr    = img_cdr[pend_addr[7:0]];
          end
        end
      end else if (!mem_dead && mem_read_enable) begin
        pend_wr   = 1'b0;
        pend_addr = mem_addr;
        pend_cnt  = 2;
      end else if (!mem_dead && mem_write_enable) begin
        pend_wr   = 1'b1;
        pend_type = mem_data_type;
        pend_car  = mem_car_data;
        pend_cdr  = mem_cdr_data;
        pend_cnt  = 2;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read_enable && mem_write_enable) begin
        checks++;
        failures++;
        $display("FAIL req_overlap actual=both expected=one");
      end
      if (mem_read_enable) begin
        last_rd_cyc = cyc;
        if (rd_q.size() == 0) check("unexpected_read", {1'b1, mem_addr}, 0);
        else check("read_addr", mem_addr, rd_q.pop_front());
      end
      if (mem_write_enable) begin
        if (wr_q.size() == 0)
          check("unexpected_write", {1'b1, mem_data_type, mem_car_data, mem_cdr_data}, 0);
        else
          check("write_payload", {mem_data_type, mem_car_data, mem_cdr_data}, wr_q.pop_front());
      end
      if (done) begin
        logic [41:0] e;
        done_cnt++;
        if (done_q.size() == 0) begin
          check("unexpected_done", {1'b1, err_code}, 0);
        end else begin
          e = done_q.pop_front();
          check("done_err",   err_code, e[41:40]);
          check("done_sum",   sum,      e[39:24]);
          check("done_count", count,    e[23:16]);
          check("done_busy",  busy,     1'b0);
          if (e[41:40] == 2'd0) check("done_result_ptr", result_ptr, e[15:0]);
          if (e[41:40] == 2'd3) check("timeout_latency", cyc - last_rd_cyc, MEM_TIMEOUT);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic issue_start(input logic [15:0] ptr);
    wait_idle();
    @(negedge clk);
    start    = 1'b1;
    list_ptr = ptr;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int target = done_cnt + 1;
    int n = 0;
    while (done_cnt < target && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL %s_no_done actual=timeout expected=done", name);
    end
  endtask

  task automatic push_done(input logic [1:0] e, input logic [15:0] s,
                           input logic [7:0] c, input logic [15:0] p);
    done_q.push_back({e, s, c, p});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    list_ptr = 16'h0;
    mem_dead = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", {busy, done, err_code, sum, count, result_ptr}, 0);
    check("reset_mem", {mem_read_enable, mem_addr, mem_write_enable,
                        mem_data_type, mem_car_data, mem_cdr_data}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Two-element list 5 + 3, with a stray start while busy.
    rd_q.push_back(16'h000C); rd_q.push_back(16'h0003);
    rd_q.push_back(16'h0009); rd_q.push_back(16'h0006);
    wr_q.push_back({T_NUM, 16'h0008, NIL});
    push_done(2'd0, 16'h0008, 8'd2, 16'h0022);
    issue_start(16'h000C);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    list_ptr = 16'h000F;
    @(negedge clk);
    start    = 1'b0;
    wait_done("walk_0c");

    // Empty list: no reads, write of zero.
    wr_q.push_back({T_NUM, 16'h0000, NIL});
    push_done(2'd0, 16'h0000, 8'd0, 16'h0025);
    issue_start(NIL);
    wait_done("walk_nil");

    // Car is a PRIMITIVE.
    rd_q.push_back(16'h000F); rd_q.push_back(16'h0012);
    push_done(2'd1, 16'h0000, 8'd0, 16'h0000);
    issue_start(16'h000F);
    wait_done("walk_prim");

    // Header is a NUMBER, not a CONS.
    rd_q.push_back(16'h0003);
    push_done(2'd1, 16'h0000, 8'd0, 16'h0000);
    issue_start(16'h0003);
    wait_done("walk_not_cons");

    // Self-cyclic list stops at MAX_LEN.
    for (int i = 0; i < MAX_LEN; i++) begin
      rd_q.push_back(16'h0015);
      rd_q.push_back(16'h0018);
    end
    push_done(2'd2, 16'h0004, 8'd4, 16'h0000);
    issue_start(16'h0015);
    wait_done("walk_cyclic");

    // Sum wraps: 0xFFF0 + 0x0020 = 0x0010.
    rd_q.push_back(16'h0089); rd_q.push_back(16'h0080);
    rd_q.push_back(16'h0086); rd_q.push_back(16'h0083);
    wr_q.push_back({T_NUM, 16'h0010, NIL});
    push_done(2'd0, 16'h0010, 8'd2, 16'h0028);
    issue_start(16'h0089);
    wait_done("walk_wrap");

    // Exactly MAX_LEN elements ending in NIL is accepted: 1+5+3+1.
    rd_q.push_back(16'h0090); rd_q.push_back(16'h0018);
    rd_q.push_back(16'h0093); rd_q.push_back(16'h0003);
    rd_q.push_back(16'h0096); rd_q.push_back(16'h0006);
    rd_q.push_back(16'h0099); rd_q.push_back(16'h0018);
    wr_q.push_back({T_NUM, 16'h000A, NIL});
    push_done(2'd0, 16'h000A, 8'd4, 16'h002B);
    issue_start(16'h0090);
    wait_done("walk_maxlen_ok");

    // Memory never answers.
    mem_dead = 1'b1;
    rd_q.push_back(16'h000C);
    push_done(2'd3, 16'h0000, 8'd0, 16'h0000);
    issue_start(16'h000C);
    wait_done("walk_timeout");
    mem_dead = 1'b0;

    // Reset in the middle of WaitCar.
    rd_q.push_back(16'h000C); rd_q.push_back(16'h0003);
    issue_start(16'h000C);
    begin
      int n = 0;
      while (!(mem_read_enable && mem_addr == 16'h0003) && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_reset_ctrl", {busy, done, err_code, sum, count, result_ptr}, 0);
    check("midrun_reset_mem", {mem_read_enable, mem_addr, mem_write_enable,
                               mem_data_type, mem_car_data, mem_cdr_data}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Clean walk after reset.
    rd_q.push_back(16'h000C); rd_q.push_back(16'h0003);
    rd_q.push_back(16'h0009); rd_q.push_back(16'h0006);
    wr_q.push_back({T_NUM, 16'h0008, NIL});
    push_done(2'd0, 16'h0008, 8'd2, 16'h002E);
    issue_start(16'h000C);
    wait_done("walk_after_reset");

    repeat (5) @(negedge clk);
    check("rd_q_empty",   rd_q.size(),   0);
    check("wr_q_empty",   wr_q.size(),   0);
    check("done_q_empty", done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
